// File: rtl/dest_reg_writeback_pipe.sv
// Destination-register writeback pipe.
// Carries the decoded write-register index and its RegWrite flag through
// DEPTH stages (EX, MEM, WB). At WB the index is decoded into a one-hot
// register-file write enable. Each stage also reports whether it holds a
// pending write to the decode-stage source registers, so that the hazard and
// forwarding logic can use it.

// One pipeline entry {v, dst} plus its source-match compare.
module dest_reg_writeback_stage #(
  parameter int REG_BITS = 5
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Stall,
  input  logic                v_i,
  input  logic [REG_BITS-1:0] dst_i,
  input  logic [REG_BITS-1:0] RsIdx,
  input  logic [REG_BITS-1:0] RtIdx,
  output logic                v_o,
  output logic [REG_BITS-1:0] dst_o,
  output logic                rs_hit_o,
  output logic                rt_hit_o
);

  logic                v_q,   v_d;
  logic [REG_BITS-1:0] dst_q, dst_d;

  // Next state: hold on stall, otherwise take the upstream entry.
  always_comb begin
    v_d   = v_q;
    dst_d = dst_q;
    if (!Stall) begin
      v_d   = v_i;
      dst_d = dst_i;
    end
  end

  // Entry register. Reset clears it at once, even in the middle of a stall.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      v_q   <= 1'b0;
      dst_q <= '0;
    end else begin
      v_q   <= v_d;
      dst_q <= dst_d;
    end
  end

  // Match flags. v is never set for r0, so a zero source index cannot hit.
  always_comb begin
    rs_hit_o = v_q & (dst_q == RsIdx);
    rt_hit_o = v_q & (dst_q == RtIdx);
  end

  assign v_o   = v_q;
  assign dst_o = dst_q;

endmodule

module dest_reg_writeback_pipe #(
  parameter int REG_BITS = 5,
  parameter int DEPTH    = 3
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     Stall,
  input  logic                     Flush,
  input  logic                     InRegWrite,
  input  logic [REG_BITS-1:0]      InDst,
  input  logic [REG_BITS-1:0]      RsIdx,
  input  logic [REG_BITS-1:0]      RtIdx,
  output logic [(2**REG_BITS)-1:0] WrEn,
  output logic [REG_BITS-1:0]      WrDst,
  output logic                     WrValid,
  output logic [DEPTH-1:0]         RsHit,
  output logic [DEPTH-1:0]         RtHit
);

  localparam int NREGS = 2**REG_BITS;

  // Inputs to each stage, and the state each stage holds.
  logic [DEPTH-1:0]               in_v;
  logic [DEPTH-1:0][REG_BITS-1:0] in_dst;
  logic [DEPTH-1:0]               stg_v;
  logic [DEPTH-1:0][REG_BITS-1:0] stg_dst;

  // Stage 0 capture. A flush makes this entry a bubble. A write to r0 is
  // dropped. The index is kept in both cases, so WrDst still shows it.
  always_comb begin
    in_v[0]   = InRegWrite & ~Flush & (InDst != '0);
    in_dst[0] = InDst;
  end

  genvar i;
  generate
    for (i = 1; i < DEPTH; i++) begin : g_chain
      assign in_v[i]   = stg_v[i-1];
      assign in_dst[i] = stg_dst[i-1];
    end

    for (i = 0; i < DEPTH; i++) begin : g_stage
      dest_reg_writeback_stage #(.REG_BITS(REG_BITS)) u_stage (
        .Clk      (Clk),
        .Reset    (Reset),
        .Stall    (Stall),
        .v_i      (in_v[i]),
        .dst_i    (in_dst[i]),
        .RsIdx    (RsIdx),
        .RtIdx    (RtIdx),
        .v_o      (stg_v[i]),
        .dst_o    (stg_dst[i]),
        .rs_hit_o (RsHit[i]),
        .rt_hit_o (RtHit[i])
      );
    end
  endgenerate

  assign WrDst   = stg_dst[DEPTH-1];
  assign WrValid = stg_v[DEPTH-1];

  genvar n;
  generate
    for (n = 0; n < NREGS; n++) begin : g_dec
      // One-hot decode of the WB index. All bits are zero when WB is empty.
      assign WrEn[n] = WrValid & (WrDst == REG_BITS'(n));
    end
  endgenerate

endmodule

// File: tb/tb_dest_reg_writeback_pipe.sv
// Directed test of dest_reg_writeback_pipe (REG_BITS=5, DEPTH=3).
// Inputs are driven on the falling edge and outputs are sampled after it.
module tb_dest_reg_writeback_pipe;

  logic        Clk = 1'b0;
  logic        Reset, Stall, Flush, InRegWrite;
  logic [4:0]  InDst, RsIdx, RtIdx;
  logic [31:0] WrEn;
  logic [4:0]  WrDst;
  logic        WrValid;
  logic [2:0]  RsHit, RtHit;

  int n_tests = 0;
  int n_fail  = 0;

  dest_reg_writeback_pipe #(.REG_BITS(5), .DEPTH(3)) dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush),
    .InRegWrite(InRegWrite), .InDst(InDst), .RsIdx(RsIdx), .RtIdx(RtIdx),
    .WrEn(WrEn), .WrDst(WrDst), .WrValid(WrValid), .RsHit(RsHit), .RtHit(RtHit)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then return on the following falling edge.
  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic drain();
    InRegWrite = 1'b0; InDst = '0; Stall = 1'b0; Flush = 1'b0;
    repeat (4) step();
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".wren"}, WrEn, 32'h0);
    chk({tag, ".wrvalid"}, {31'b0, WrValid}, 32'd0);
    chk({tag, ".rshit"}, {29'b0, RsHit}, 32'd0);
    chk({tag, ".rthit"}, {29'b0, RtHit}, 32'd0);
  endtask

  initial begin
    Reset = 1'b1; Stall = 1'b0; Flush = 1'b0; InRegWrite = 1'b0;
    InDst = '0; RsIdx = '0; RtIdx = '0;

    // Reset, then 5 idle cycles.
    #1;
    chk_idle("reset");
    chk("reset.wrdst", {27'b0, WrDst}, 32'd0);
    #14 Reset = 1'b0;
    @(negedge Clk);
    RsIdx = 5'd20; RtIdx = 5'd17;
    for (int c = 0; c < 5; c++) begin
      step();
      chk_idle("idle");
    end

    // Basic latency: capture r20, then WB after 3 edges for one cycle.
    InRegWrite = 1'b1; InDst = 5'b10100;
    step();
    InRegWrite = 1'b0; InDst = '0;
    step();
    chk("lat.pre.wrvalid", {31'b0, WrValid}, 32'd0);
    chk("lat.pre.wren", WrEn, 32'h0);
    step();
    chk("lat.wrvalid", {31'b0, WrValid}, 32'd1);
    chk("lat.wrdst", {27'b0, WrDst}, 32'd20);
    chk("lat.wren", WrEn, 32'h0010_0000);
    step();
    chk("lat.post.wren", WrEn, 32'h0);
    chk("lat.post.wrvalid", {31'b0, WrValid}, 32'd0);

    // Back-to-back 17, 20, 17 with per-stage hits.
    drain();
    InRegWrite = 1'b1;
    InDst = 5'd17; step();
    InDst = 5'd20; step();
    InDst = 5'd17; step();
    InRegWrite = 1'b0; InDst = '0;
    RsIdx = 5'd17; RtIdx = 5'd20; #1;
    chk("b2b.rshit", {29'b0, RsHit}, 32'b101);
    chk("b2b.rthit", {29'b0, RtHit}, 32'b010);
    chk("b2b.wb0", WrEn, 32'h0002_0000);
    step();
    chk("b2b.wb1", WrEn, 32'h0010_0000);
    step();
    chk("b2b.wb2", WrEn, 32'h0002_0000);
    step();
    chk("b2b.wb3", WrEn, 32'h0);

    // Writes to r0 and flushed entries never write back or hit.
    drain();
    InRegWrite = 1'b1; InDst = 5'd0;
    step();
    RsIdx = 5'd0; RtIdx = 5'd0; #1;
    chk("zero.rshit", {29'b0, RsHit}, 32'd0);
    chk("zero.rthit", {29'b0, RtHit}, 32'd0);
    InDst = 5'd20; Flush = 1'b1;
    step();
    Flush = 1'b0; InRegWrite = 1'b0; InDst = '0;
    RsIdx = 5'd20; #1;
    chk("flush.rshit", {29'b0, RsHit}, 32'd0);
    step();
    chk("zero.wb.wren", WrEn, 32'h0);
    chk("zero.wb.wrvalid", {31'b0, WrValid}, 32'd0);
    step();
    chk("flush.wb.wren", WrEn, 32'h0);
    chk("flush.wb.wrdst", {27'b0, WrDst}, 32'd20);
    chk("flush.wb.wrvalid", {31'b0, WrValid}, 32'd0);

    // Stall for 2 edges after capturing r20. r17 must not be captured.
    drain();
    RsIdx = 5'd20; RtIdx = 5'd17;
    InRegWrite = 1'b1; InDst = 5'd20;
    step();
    Stall = 1'b1; InDst = 5'd17;
    for (int c = 0; c < 2; c++) begin
      step();
      chk("stall.rshit", {29'b0, RsHit}, 32'b001);
      chk("stall.rthit", {29'b0, RtHit}, 32'b000);
      chk("stall.wren", WrEn, 32'h0);
    end
    Stall = 1'b0; InRegWrite = 1'b0; InDst = '0;
    step();
    chk("stall.late.wren", WrEn, 32'h0);
    step();
    chk("stall.wb.wren", WrEn, 32'h0010_0000);
    step();
    chk("stall.post.wren", WrEn, 32'h0);

    // Stall together with flush keeps the valid entry already in stage 0.
    drain();
    RsIdx = 5'd17;
    InRegWrite = 1'b1; InDst = 5'd17;
    step();
    Stall = 1'b1; Flush = 1'b1; InDst = 5'd3;
    step();
    chk("stallflush.rshit", {29'b0, RsHit}, 32'b001);
    Stall = 1'b0; Flush = 1'b0; InRegWrite = 1'b0; InDst = '0;

    // Asynchronous reset between edges while 3 valid entries are in flight.
    drain();
    InRegWrite = 1'b1;
    InDst = 5'd5; step();
    InDst = 5'd6; step();
    InDst = 5'd7; step();
    InRegWrite = 1'b0; InDst = '0;
    RsIdx = 5'd6; RtIdx = 5'd7; #1;
    chk("arst.pre.wren", WrEn, 32'h0000_0020);
    chk("arst.pre.rshit", {29'b0, RsHit}, 32'b010);
    #1 Reset = 1'b1;
    #1;
    chk_idle("arst");
    chk("arst.wrdst", {27'b0, WrDst}, 32'd0);
    #1 Reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("arst.after.wren", WrEn, 32'h0);
      chk("arst.after.wrvalid", {31'b0, WrValid}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dest_reg_writeback_pipe.md
Name: dest_reg_writeback_pipe

Overview:
- Receiving end of the destination-register select path.
- Takes the 5-bit write-register index chosen in decode (rt or rd) plus its RegWrite flag, and carries them through the EX/MEM/WB pipeline stages.
- At writeback, decodes the index into a one-hot register-file write-enable vector.
- Exposes per-stage match flags against the current source registers for the hazard/forwarding logic.

Parameters:
- REG_BITS, 5, width of a register index; register file has 2**REG_BITS entries.
- DEPTH, 3, number of pipeline stages between input and writeback (EX, MEM, WB); legal range 1..8.

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-high; clears all stages.
- Stall  input  1  when 1, all stage registers hold.
- Flush  input  1  when 1, the entry being captured into stage 0 is forced invalid (bubble).
- InRegWrite  input  1  RegWrite control for the incoming instruction.
- InDst  input  REG_BITS  selected destination register index (mux output).
- RsIdx  input  REG_BITS  source register rs of the instruction in decode.
- RtIdx  input  REG_BITS  source register rt of the instruction in decode.
- WrEn  output  2**REG_BITS  one-hot write enable to the register file (all zero when no write).
- WrDst  output  REG_BITS  index held in the last stage.
- WrValid  output  1  last stage holds a valid write to a nonzero register.
- RsHit  output  DEPTH  bit i = stage i holds a valid write whose index equals RsIdx.
- RtHit  output  DEPTH  bit i = stage i holds a valid write whose index equals RtIdx.

Behaviour:
- State: DEPTH entries, each {v, dst[REG_BITS-1:0]}; stage 0 is nearest the input, stage DEPTH-1 is WB.
- Reset (async, any time, including mid-stall): all v=0, all dst=0. Outputs WrEn=0, WrDst=0, WrValid=0, RsHit=0, RtHit=0 immediately, without waiting for a clock edge.
- Rising Clk, Reset=0, Stall=0:
  - stage0 <= {InRegWrite & ~Flush & (InDst != 0), InDst}
  - stage i <= stage i-1 for i >= 1
- Register 0 is never a valid write. An entry with InDst=0 is captured with v=0, while dst keeps the index.
- Stall=1: every stage holds, regardless of Flush or inputs. Stall has priority over Flush.
- Flush=1, Stall=0: stage 0 captures v=0 and dst=InDst; older stages shift normally, so in-flight instructions still retire.
- Latency: an instruction presented at edge k appears at WB after edge k+DEPTH-1 and drives WrEn during the following cycle, i.e. DEPTH edges after capture with no stalls. Each stalled cycle adds one cycle.
- Outputs are combinational from the stage registers only, with no path from InDst/InRegWrite:
  - WrDst = stage[DEPTH-1].dst
  - WrValid = stage[DEPTH-1].v
  - WrEn[n] = WrValid & (WrDst == n); at most one bit is set.
  - RsHit[i] = stage[i].v & (stage[i].dst == RsIdx); RtHit likewise with RtIdx. RsIdx=0 or RtIdx=0 therefore never hits.
- Multiple stages may hit the same source simultaneously; all corresponding bits assert. Priority resolution belongs to the consumer.
- No wrap-around or overflow: a pure shift structure. Entries leaving WB are discarded.

Test Plan:
- Reset then idle: assert Reset for 15 ns, release, run 5 cycles with InRegWrite=0 -> WrEn=0, WrValid=0, RsHit=RtHit=0 throughout.
- Basic latency: edge 0, InRegWrite=1, InDst=5'b10100, then InRegWrite=0 -> after 3 edges WrValid=1, WrDst=20, WrEn=32'h0010_0000 for exactly one cycle, then 0.
- Back-to-back and hits: capture dst 17, 20, 17 on consecutive edges; with RsIdx=17, RtIdx=20 after the third edge -> RsHit=3'b101, RtHit=3'b010. The next three WB cycles show WrEn bits 17, 20, 17.
- Zero register and flush: capture dst 0 with InRegWrite=1, then dst 20 with Flush=1 -> neither produces WrEn, and RsIdx=0 / RsIdx=20 give no hit.
- Stall: capture dst 20, assert Stall for 2 edges while InDst=17 and InRegWrite=1 -> stage contents unchanged during the stall, dst 17 not captured; WrEn bit 20 appears 2 cycles later than in the unstalled case. Stall+Flush together also hold stage 0's prior valid entry.
- Async reset mid-flight: 3 valid entries in the pipe, assert Reset between clock edges -> all outputs 0 before the next edge; after release nothing is written back.
